// File: rtl/usb_host_tx_serializer.sv
// usb_host_tx_serializer
//
// Host-side USB full/low-speed transmit serializer. Takes bytes through a
// valid/accept handshake and drives NRZI-encoded, bit-stuffed D+/D- line
// states framed by SYNC and EOP. Can also drive a commanded bus reset (long
// SE0) and deliberately corrupt a packet by disabling bit stuffing.
//
// Parameters:
//   CLK_DIV      clocks per bit time (>= 2)
//   SYNC_BITS    SYNC length in bits (8 or 32)
//   RESET_LEN_W  width of the bus-reset length operand
//
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   txReqSendPacket_i      start-packet request (sampled in IDLE)
//   txDataValid_i          txData_i holds a valid byte
//   txData_i               byte to send, LSB first
//   txIsLastByte_i         byte on txData_i ends the packet
//   txAcceptNewData_o      high during the clock whose closing edge latches a byte
//   injectStuffErr_i       disable stuffing for the packet being started
//   busResetReq_i          bus-reset request (sampled in IDLE, wins over packet)
//   busResetLen_i          bus-reset SE0 length in bit times (0 acts as 1)
//   USB_DP_o, USB_DN_o     line state
//   USB_OE_o               driver enable
//   sending_o              packet in flight
//   busResetActive_o       bus-reset SE0 being driven

module usb_host_tx_serializer #(
    parameter int CLK_DIV     = 4,
    parameter int SYNC_BITS   = 8,
    parameter int RESET_LEN_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   txReqSendPacket_i,
    input  logic                   txDataValid_i,
    input  logic [7:0]             txData_i,
    input  logic                   txIsLastByte_i,
    output logic                   txAcceptNewData_o,
    input  logic                   injectStuffErr_i,
    input  logic                   busResetReq_i,
    input  logic [RESET_LEN_W-1:0] busResetLen_i,
    output logic                   USB_DP_o,
    output logic                   USB_DN_o,
    output logic                   USB_OE_o,
    output logic                   sending_o,
    output logic                   busResetActive_o
);

    localparam int DIV_W = $clog2(CLK_DIV);
    // Bit counter must hold both the SYNC length and a full-range reset length.
    localparam int CNT_W = (RESET_LEN_W > 6) ? RESET_LEN_W : 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP_SE0,
        ST_EOP_J,
        ST_BUS_RESET,
        ST_ABORT
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             level_q, level_d;      // 1 = J, 0 = K
    logic [7:0]       data_q, data_d;
    logic             last_q, last_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             stuff_q, stuff_d;      // current bit is an inserted stuff bit
    logic [2:0]       ones_q, ones_d;        // consecutive ones incl. current bit
    logic             inject_q, inject_d;
    logic             rst_mode_q, rst_mode_d; // EOP_J belongs to a bus reset, not a packet

    logic strobe;
    logic do_fetch;
    logic send_bit;
    logic next_bit;
    logic accept;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            level_q    <= 1'b1;
            data_q     <= '0;
            last_q     <= 1'b0;
            bit_idx_q  <= '0;
            stuff_q    <= 1'b0;
            ones_q     <= '0;
            inject_q   <= 1'b0;
            rst_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            level_q    <= level_d;
            data_q     <= data_d;
            last_q     <= last_d;
            bit_idx_q  <= bit_idx_d;
            stuff_q    <= stuff_d;
            ones_q     <= ones_d;
            inject_q   <= inject_d;
            rst_mode_q <= rst_mode_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        level_d    = level_q;
        data_d     = data_q;
        last_d     = last_q;
        bit_idx_d  = bit_idx_q;
        stuff_d    = stuff_q;
        ones_d     = ones_q;
        inject_d   = inject_q;
        rst_mode_d = rst_mode_q;
        do_fetch   = 1'b0;
        send_bit   = 1'b0;
        next_bit   = 1'b1;
        accept     = 1'b0;

        strobe = (div_q == DIV_W'(CLK_DIV - 1));
        div_d  = strobe ? '0 : div_q + DIV_W'(1);

        case (state_q)
            ST_IDLE: begin
                div_d   = '0;
                level_d = 1'b1;
                if (busResetReq_i) begin
                    state_d    = ST_BUS_RESET;
                    inject_d   = injectStuffErr_i;
                    rst_mode_d = 1'b1;
                    if (busResetLen_i == '0) begin
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = CNT_W'(busResetLen_i) - CNT_W'(1);
                    end
                end else if (txReqSendPacket_i) begin
                    state_d    = ST_SYNC;
                    inject_d   = injectStuffErr_i;
                    rst_mode_d = 1'b0;
                    bit_cnt_d  = CNT_W'(SYNC_BITS - 1);
                    // First SYNC bit is a 0, so the line toggles from idle J to K.
                    level_d    = 1'b0;
                    ones_d     = '0;
                end
            end

            ST_SYNC: begin
                if (strobe) begin
                    if (bit_cnt_q == '0) begin
                        do_fetch = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q - CNT_W'(1);
                        send_bit  = 1'b1;
                        next_bit  = (bit_cnt_q == CNT_W'(1));
                    end
                end
            end

            ST_DATA: begin
                if (strobe) begin
                    // Stuff check comes first so a stuff bit due after bit 7
                    // still goes out before the next fetch or EOP.
                    if (!inject_q && ones_q == 3'd6) begin
                        send_bit = 1'b1;
                        next_bit = 1'b0;
                        stuff_d  = 1'b1;
                    end else if (bit_idx_q == 3'd7) begin
                        if (last_q) begin
                            state_d   = ST_EOP_SE0;
                            bit_cnt_d = CNT_W'(1);
                        end else begin
                            do_fetch = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        stuff_d   = 1'b0;
                        send_bit  = 1'b1;
                        next_bit  = data_q[bit_idx_q + 3'd1];
                    end
                end
            end

            ST_ABORT: begin
                if (strobe) begin
                    if (bit_cnt_q == '0) begin
                        state_d   = ST_EOP_SE0;
                        bit_cnt_d = CNT_W'(1);
                    end else begin
                        bit_cnt_d = bit_cnt_q - CNT_W'(1);
                    end
                end
            end

            ST_EOP_SE0, ST_BUS_RESET: begin
                if (strobe) begin
                    if (bit_cnt_q == '0) begin
                        state_d = ST_EOP_J;
                    end else begin
                        bit_cnt_d = bit_cnt_q - CNT_W'(1);
                    end
                end
            end

            ST_EOP_J: begin
                if (strobe) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Byte slot boundary: take the next byte, or abort on underrun. The
        // abort keeps the line level, which is exactly an unstuffed run of 1s.
        if (do_fetch) begin
            if (txDataValid_i) begin
                accept    = 1'b1;
                data_d    = txData_i;
                last_d    = txIsLastByte_i;
                bit_idx_d = '0;
                stuff_d   = 1'b0;
                state_d   = ST_DATA;
                send_bit  = 1'b1;
                next_bit  = txData_i[0];
            end else begin
                state_d   = ST_ABORT;
                bit_cnt_d = CNT_W'(6);
            end
        end

        // NRZI: a 0 toggles the line, a 1 holds it.
        if (send_bit) begin
            level_d = next_bit ? level_q : ~level_q;
            if (next_bit) begin
                ones_d = (ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1;
            end else begin
                ones_d = '0;
            end
        end
    end

    always_comb begin
        USB_DP_o = 1'b1;
        USB_DN_o = 1'b0;
        USB_OE_o = 1'b1;
        case (state_q)
            ST_IDLE: begin
                USB_OE_o = 1'b0;
            end
            ST_SYNC, ST_DATA, ST_ABORT: begin
                USB_DP_o = level_q;
                USB_DN_o = ~level_q;
            end
            ST_EOP_SE0, ST_BUS_RESET: begin
                USB_DP_o = 1'b0;
                USB_DN_o = 1'b0;
            end
            default: begin
                USB_DP_o = 1'b1;
                USB_DN_o = 1'b0;
            end
        endcase
    end

    assign txAcceptNewData_o = accept;
    assign sending_o         = (state_q != ST_IDLE) && !rst_mode_q;
    assign busResetActive_o  = (state_q == ST_BUS_RESET);

endmodule

// File: tb/tb_usb_host_tx_serializer.sv
// Testbench for usb_host_tx_serializer: table of single-byte packets with
// hand-computed line sequences, plus sequences for reset, underrun and
// bus reset.

module tb_usb_host_tx_serializer;

    localparam int CLK_DIV     = 4;
    localparam int SYNC_BITS   = 8;
    localparam int RESET_LEN_W = 16;

    // {OE, DP, DN}
    localparam logic [2:0] LJ    = 3'b110;
    localparam logic [2:0] LK    = 3'b101;
    localparam logic [2:0] LSE0  = 3'b100;
    localparam logic [2:0] LIDLE = 3'b010;

    logic                   clk_i = 1'b0;
    logic                   rstn_i = 1'b0;
    logic                   txReqSendPacket_i = 1'b0;
    logic                   txDataValid_i = 1'b0;
    logic [7:0]             txData_i = 8'h00;
    logic                   txIsLastByte_i = 1'b0;
    logic                   txAcceptNewData_o;
    logic                   injectStuffErr_i = 1'b0;
    logic                   busResetReq_i = 1'b0;
    logic [RESET_LEN_W-1:0] busResetLen_i = '0;
    logic                   USB_DP_o;
    logic                   USB_DN_o;
    logic                   USB_OE_o;
    logic                   sending_o;
    logic                   busResetActive_o;

    int checks = 0;
    int errors = 0;

    int mon_en = 0;
    int mon_clk = 0;
    int mon_send = 0;
    int mon_acc = 0;
    int mon_acc_clk = -1;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       inject;
        int         nbits;
        logic [15:0] levels;   // data-region line level per bit time, 1 = J
        int         send_clks;
    } vec_t;

    vec_t vecs[7];

    always #5 clk_i = ~clk_i;

    usb_host_tx_serializer #(
        .CLK_DIV    (CLK_DIV),
        .SYNC_BITS  (SYNC_BITS),
        .RESET_LEN_W(RESET_LEN_W)
    ) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .txReqSendPacket_i(txReqSendPacket_i),
        .txDataValid_i    (txDataValid_i),
        .txData_i         (txData_i),
        .txIsLastByte_i   (txIsLastByte_i),
        .txAcceptNewData_o(txAcceptNewData_o),
        .injectStuffErr_i (injectStuffErr_i),
        .busResetReq_i    (busResetReq_i),
        .busResetLen_i    (busResetLen_i),
        .USB_DP_o         (USB_DP_o),
        .USB_DN_o         (USB_DN_o),
        .USB_OE_o         (USB_OE_o),
        .sending_o        (sending_o),
        .busResetActive_o (busResetActive_o)
    );

    // Counts clocks since a request edge, clocks with sending_o high, and
    // accept pulses with the clock index of the latest one.
    always @(negedge clk_i) begin
        if (mon_en != 0) begin
            mon_clk = mon_clk + 1;
            if (sending_o) mon_send = mon_send + 1;
            if (txAcceptNewData_o) begin
                mon_acc = mon_acc + 1;
                mon_acc_clk = mon_clk;
            end
        end
    end

    function automatic logic [2:0] lineNow();
        return {USB_OE_o, USB_DP_o, USB_DN_o};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic valid, input logic [7:0] data,
                                 input logic last, input logic inject, input logic brq,
                                 input logic [RESET_LEN_W-1:0] blen);
        txReqSendPacket_i = req;
        txDataValid_i     = valid;
        txData_i          = data;
        txIsLastByte_i    = last;
        injectStuffErr_i  = inject;
        busResetReq_i     = brq;
        busResetLen_i     = blen;
    endtask

    task automatic startMonitor();
        mon_clk     = 0;
        mon_send    = 0;
        mon_acc     = 0;
        mon_acc_clk = -1;
        mon_en      = 1;
    endtask

    // Sends one packet and checks the line in the middle of every bit time.
    // In underrun mode the first byte is not last and valid drops after it.
    task automatic runPacket(input string name, input logic [7:0] data, input logic inject,
                             input logic underrun, input int nbits, input logic [15:0] levels,
                             input int send_clks);
        int total;
        logic [2:0] exp;
        logic [7:0] sync_lev;
        sync_lev = 8'h2A;   // K J K J K J K K
        total = SYNC_BITS + nbits + 3;
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b1, data, !underrun, inject, 1'b0, '0);
        @(posedge clk_i);
        startMonitor();
        @(negedge clk_i);
        txReqSendPacket_i = 1'b0;
        @(negedge clk_i);
        for (int k = 0; k < total; k++) begin
            if (k > 0) repeat (CLK_DIV) @(negedge clk_i);
            if (k < SYNC_BITS) exp = sync_lev[k] ? LJ : LK;
            else if (k < SYNC_BITS + nbits) exp = levels[k - SYNC_BITS] ? LJ : LK;
            else if (k < total - 1) exp = LSE0;
            else exp = LJ;
            checkOutput($sformatf("%s bit%0d", name, k), 32'(lineNow()), 32'(exp));
            if (underrun && k == SYNC_BITS) txDataValid_i = 1'b0;
        end
        repeat (3) @(negedge clk_i);
        checkOutput({name, " idle line"}, 32'(lineNow()), 32'(LIDLE));
        checkOutput({name, " idle sending"}, 32'(sending_o), 32'd0);
        mon_en = 0;
        checkOutput({name, " sending clocks"}, mon_send, send_clks);
        checkOutput({name, " accept count"}, mon_acc, 1);
        checkOutput({name, " accept clock"}, mon_acc_clk, SYNC_BITS * CLK_DIV);
        txDataValid_i  = 1'b0;
        txIsLastByte_i = 1'b0;
        injectStuffErr_i = 1'b0;
    endtask

    initial begin
        int se0_ok;
        int j_ok;

        vecs[0] = '{"A5",        8'hA5, 1'b0, 8, 16'h0036, 76};
        vecs[1] = '{"FF",        8'hFF, 1'b0, 9, 16'h01E0, 80};
        vecs[2] = '{"FF inject", 8'hFF, 1'b1, 8, 16'h0000, 76};
        vecs[3] = '{"00",        8'h00, 1'b0, 8, 16'h0055, 76};
        vecs[4] = '{"7F",        8'h7F, 1'b0, 9, 16'h00E0, 80};
        vecs[5] = '{"3F",        8'h3F, 1'b0, 9, 16'h0160, 80};
        vecs[6] = '{"FC",        8'hFC, 1'b0, 9, 16'h0101, 80};

        // Reset values while held in reset.
        repeat (3) @(negedge clk_i);
        checkOutput("reset outputs",
                    32'({USB_DP_o, USB_DN_o, USB_OE_o, sending_o, txAcceptNewData_o, busResetActive_o}),
                    32'(6'b100000));
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checkOutput("post-reset idle", 32'(lineNow()), 32'(LIDLE));

        // Back-to-back single-byte packets from the table.
        for (int i = 0; i < 7; i++) begin
            runPacket(vecs[i].name, vecs[i].data, vecs[i].inject, 1'b0,
                      vecs[i].nbits, vecs[i].levels, vecs[i].send_clks);
        end

        // Asynchronous reset in the middle of SYNC.
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, '0);
        @(posedge clk_i);
        startMonitor();
        @(negedge clk_i);
        txReqSendPacket_i = 1'b0;
        repeat (9) @(negedge clk_i);
        #1 rstn_i = 1'b0;
        #1;
        checkOutput("midsync reset line", 32'(lineNow()), 32'(LIDLE));
        checkOutput("midsync reset sending", 32'(sending_o), 32'd0);
        checkOutput("midsync reset accept", 32'(txAcceptNewData_o), 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (60) @(negedge clk_i);
        mon_en = 0;
        checkOutput("midsync post line", 32'(lineNow()), 32'(LIDLE));
        checkOutput("midsync post accept count", mon_acc, 0);
        txDataValid_i = 1'b0;

        // Underrun: byte 0x01 not last, then nothing valid -> 7 held bits.
        runPacket("underrun", 8'h01, 1'b0, 1'b1, 15, 16'h7FAA, 104);

        // Bus reset wins over a simultaneous packet request.
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd10);
        @(posedge clk_i);
        se0_ok = 0;
        j_ok = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk_i);
            if (c == 1) begin
                txReqSendPacket_i = 1'b0;
                busResetReq_i = 1'b0;
            end
            if (c <= 40) begin
                if (lineNow() == LSE0 && busResetActive_o && !sending_o) se0_ok++;
            end else if (c <= 44) begin
                if (lineNow() == LJ && !busResetActive_o && !sending_o) j_ok++;
            end else begin
                checkOutput("busreset end",
                            32'({lineNow(), busResetActive_o, sending_o}),
                            32'({LIDLE, 2'b00}));
            end
        end
        checkOutput("busreset se0 clocks", se0_ok, 40);
        checkOutput("busreset J clocks", j_ok, 4);
        repeat (4) @(negedge clk_i);
        checkOutput("busreset no restart",
                    32'({lineNow(), sending_o}), 32'({LIDLE, 1'b0}));
        runPacket("A5 after reset", 8'hA5, 1'b0, 1'b0, 8, 16'h0036, 76);

        // Zero reset length behaves as one bit time.
        @(negedge clk_i);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0);
        @(posedge clk_i);
        se0_ok = 0;
        j_ok = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_i);
            if (c == 1) busResetReq_i = 1'b0;
            if (lineNow() == LSE0 && busResetActive_o) se0_ok++;
            if (lineNow() == LJ) j_ok++;
        end
        checkOutput("zero-len se0 clocks", se0_ok, 4);
        checkOutput("zero-len J clocks", j_ok, 4);
        checkOutput("zero-len idle", 32'(lineNow()), 32'(LIDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_host_tx_serializer.md
# usb_host_tx_serializer

Parametrised host-side USB full/low-speed transmit serializer for the simulation top. It supersedes the fixed 12 MHz host TX imitator. It runs on one oversampling clock and turns a byte-stream handshake into NRZI, bit-stuffed D+/D- line states with SYNC and EOP framing. It also adds two bus-level features the previous imitator lacked: commanded bus-reset (SE0) injection and bit-stuff-error (abort) generation.

## Interface
- CLK_DIV, 4: clocks per bit time; must be ≥ 2. 4 gives 12 Mbit/s at 48 MHz.
- SYNC_BITS, 8: SYNC length in bits; legal values are 8 or 32.
- RESET_LEN_W, 16: width of the bus-reset length operand.

Ports (clock and reset first):
- clk_i  in  1  single clock for all logic.
- rstn_i  in  1  asynchronous, active-low reset.
- txReqSendPacket_i  in  1  start-packet request; sampled only in IDLE.
- txDataValid_i  in  1  txData_i holds a valid byte.
- txData_i  in  8  byte to send, transmitted LSB first.
- txIsLastByte_i  in  1  the byte on txData_i is the final byte of the packet.
- txAcceptNewData_o  out  1  one-clock pulse: byte latched this clock.
- injectStuffErr_i  in  1  latched at packet start; when set, stuffing is disabled for that packet.
- busResetReq_i  in  1  bus-reset request; sampled only in IDLE.
- busResetLen_i  in  RESET_LEN_W  SE0 length in bit times; 0 is treated as 1.
- USB_DP_o, USB_DN_o  out  1 each  line state.
- USB_OE_o  out  1  driver enable.
- sending_o  out  1  packet in flight.
- busResetActive_o  out  1  reset SE0 being driven.

## Operation
- Line states: J = (DP 1, DN 0), K = (0, 1), SE0 = (0, 0).
- NRZI encoding: a 0 toggles J/K; a 1 holds the current state.
- States:
  - IDLE: drives J, OE = 0.
  - SYNC: SYNC_BITS-1 zeros, then a single 1.
  - DATA: byte bits, with stuff bits inserted.
  - EOP_SE0: 2 bit times of SE0.
  - EOP_J: 1 bit time of J, then IDLE.
  - BUS_RESET: SE0 for max(busResetLen_i, 1) bit times, then EOP_J, then IDLE.
  - ABORT: 7 consecutive unstuffed 1s, then EOP_SE0.
- IDLE priority: if busResetReq_i and txReqSendPacket_i are both high, BUS_RESET wins and the packet request is ignored. The host holds its request until sending_o rises.
- On leaving IDLE:
  - injectStuffErr_i and busResetLen_i are latched.
  - The bit divider restarts at 0 and emits a bit strobe every CLK_DIV clocks.
- Byte fetch happens at the strobe that begins each byte slot (end of SYNC, or end of the previous byte's last bit including any pending stuff bit).
  - If txDataValid_i = 1: latch txData_i and txIsLastByte_i, and pulse txAcceptNewData_o.
  - If txDataValid_i = 0 (underrun): go to ABORT and do not pulse.
- Bit stuffing:
  - The ones counter is 1 entering DATA, because the SYNC's trailing 1 counts.
  - When the counter reaches 6, a 0 is inserted for one bit time and the counter clears. Any 0 also clears it.
  - A stuff bit that falls due after the last data bit is sent before EOP.
  - Stuffing is suppressed entirely when the latched inject flag is set.
- After the last bit of the last byte, go to EOP_SE0.
- USB_OE_o is 1 in every state except IDLE.
- sending_o is 1 from the clock after the request is accepted until IDLE is re-entered; it is 0 during bus reset.
- busResetActive_o is 1 only during BUS_RESET's SE0 phase.
- Reset mid-operation: all state is abandoned immediately (asynchronously).

## Timing
- Reset values: DP 1, DN 0, OE 0, sending_o 0, txAcceptNewData_o 0, busResetActive_o 0, state IDLE, divider 0, ones counter 0.
- A request sampled at edge t puts the first SYNC bit on the line from t+1. Every bit lasts exactly CLK_DIV clocks.
- The first byte is latched at edge t + SYNC_BITS·CLK_DIV.
- Packet of N bytes with S stuff bits: sending_o is high for (SYNC_BITS + 8N + S + 3)·CLK_DIV clocks.
- A new request is accepted at the first IDLE clock, so the inter-packet gap is 1 clock minimum.
- Bus reset: SE0 lasts L·CLK_DIV clocks, followed by CLK_DIV clocks of J.
- The bit-time counter must hold busResetLen_i up to 2^RESET_LEN_W − 1 without wrapping.

## Test plan
- Assert rstn_i = 0 in mid-SYNC → same cycle: J, OE 0, sending_o 0; after release, IDLE with no spurious accept pulse.
- Send 0xA5 (last), CLK_DIV = 4, SYNC_BITS = 8 → line KJKJKJKK, then data bits 1,0,1,0,0,1,0,1 NRZI-encoded, SE0 SE0 J; sending_o high for 76 clocks; one accept pulse at clock 32.
- Send 0xFF (last) → stuff 0 after data bit 4; the last byte plus stuff bit spans 9 bit times; sending_o high 80 clocks.
- Send 0xFF with injectStuffErr_i = 1 → no stuff bit, line held 9 bit times (SYNC's trailing 1 plus 8 data ones); sending_o high 76 clocks.
- Two-byte packet with txDataValid_i = 0 at the second fetch → line held for 7 bit times, then EOP; exactly one accept pulse.
- busResetReq_i and txReqSendPacket_i both high with busResetLen_i = 10 → SE0 40 clocks with busResetActive_o high, then J 4 clocks; sending_o stays 0; the packet starts only after re-request.
